dmem_access_ctrl: RTL and testbench

- MA-stage memory access controller between the pipeline's load/store request and the word-only data memory.
- Converts RV32 byte, halfword and word loads/stores into aligned 32-bit memory transactions.
- Partial stores use read-modify-write. Loads are extracted with sign or zero extension.
- Stalls the pipeline through busywait until each access completes.

---
 rtl/dmem_access_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// dmem_access_ctrl: MA-stage byte/half/word load-store controller over a word-only data memory.
// Optional one-entry word buffer enabled by DMEM_WORD_BUF_EN.  Rev 1.0
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int BUSY_TIMEOUT = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            read,
  input  logic [2:0]            write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  busywait,
  output logic                  access_err,
  output logic [3:0]            mem_read,
  output logic [2:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata,
  input  logic                  mem_busywait
);

  localparam int         TMO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [3:0] MEM_RD = 4'b1010;
  localparam logic [2:0] MEM_WR = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            f3_q, f3_d;     // load funct3, or {1'b0,size} for stores
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  err_q, err_d;
  logic [3:0]            mem_read_q, mem_read_d;
  logic [2:0]            mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [31:0]           mem_writedata_q, mem_writedata_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                  w_ld, w_st, w_bad, w_tmo, w_buf_hit;
  logic [TMO_W-1:0]      w_tmo_inc;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [31:0]           w_buf_data;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[{off, 3'b000} +: 8] = d[7:0];
    else             r[{off[1], 4'b0000} +: 16] = d[15:0];
    return r;
  endfunction

  assign w_ld      = read[3];
  assign w_st      = write[2];
  assign w_waddr   = {address[ADDR_WIDTH-1:2], 2'b00};
  assign w_tmo_inc = tmo_q + TMO_W'(1);
  assign w_tmo     = (BUSY_TIMEOUT != 0) && (w_tmo_inc == TMO_W'(BUSY_TIMEOUT));

  always_comb begin
    w_bad = 1'b0;
    if (w_ld && w_st) begin
      w_bad = 1'b1;
    end else if (w_ld) begin
      case (read[2:0])
        3'b000, 3'b100: w_bad = 1'b0;
        3'b001, 3'b101: w_bad = address[0];
        3'b010:         w_bad = |address[1:0];
        default:        w_bad = 1'b1;
      endcase
    end else if (w_st) begin
      case (write[1:0])
        2'b00:   w_bad = 1'b0;
        2'b01:   w_bad = address[0];
        2'b10:   w_bad = |address[1:0];
        default: w_bad = 1'b1;
      endcase
    end
  end

`ifdef DMEM_WORD_BUF_EN
  logic                  buf_vld_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [31:0]           buf_data_q;

  assign w_buf_hit  = buf_vld_q && (buf_addr_q == w_waddr);
  assign w_buf_data = buf_data_q;

  // Every completed phase leaves the buffer holding the word last seen on the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else if (!mem_busywait) begin
      if (state_q == S_LOAD || state_q == S_RMW_RD) begin
        buf_vld_q  <= 1'b1;
        buf_addr_q <= mem_address_q;
        buf_data_q <= mem_readdata;
      end else if (state_q == S_STORE || state_q == S_RMW_WR) begin
        buf_vld_q  <= 1'b1;
        buf_addr_q <= mem_address_q;
        buf_data_q <= mem_writedata_q;
      end
    end
  end
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_data = 32'd0;
`endif

  always_comb begin
    state_d         = state_q;
    f3_d            = f3_q;
    off_d           = off_q;
    wdata_d         = wdata_q;
    readdata_d      = readdata_q;
    err_d           = 1'b0;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    tmo_d           = '0;
    busywait        = 1'b1;
    case (state_q)
      S_IDLE: begin
        busywait = w_ld ^ w_st;
        if (w_ld || w_st) begin
          f3_d    = w_ld ? read[2:0] : {1'b0, write[1:0]};
          off_d   = address[1:0];
          wdata_d = writedata;
          if (w_bad) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (w_ld) begin
            if (w_buf_hit) begin
              readdata_d = extract(w_buf_data, read[2:0], address[1:0]);
              state_d    = S_DONE;
            end else begin
              state_d       = S_LOAD;
              mem_read_d    = MEM_RD;
              mem_address_d = w_waddr;
            end
          end else if (write[1:0] == 2'b10) begin
            state_d         = S_STORE;
            mem_write_d     = MEM_WR;
            mem_address_d   = w_waddr;
            mem_writedata_d = writedata;
          end else if (w_buf_hit) begin
            state_d         = S_RMW_WR;
            mem_write_d     = MEM_WR;
            mem_address_d   = w_waddr;
            mem_writedata_d = merge(w_buf_data, writedata, write[1:0], address[1:0]);
          end else begin
            state_d       = S_RMW_RD;
            mem_read_d    = MEM_RD;
            mem_address_d = w_waddr;
          end
        end
      end
      S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR: begin
        if (!mem_busywait) begin
          mem_read_d  = '0;
          mem_write_d = '0;
          state_d     = S_DONE;
          if (state_q == S_LOAD) readdata_d = extract(mem_readdata, f3_q, off_q);
          if (state_q == S_RMW_RD) begin
            state_d         = S_RMW_WR;
            mem_write_d     = MEM_WR;
            mem_writedata_d = merge(mem_readdata, wdata_q, f3_q[1:0], off_q);
          end
        end else if (w_tmo) begin
          mem_read_d  = '0;
          mem_write_d = '0;
          err_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          tmo_d = w_tmo_inc;
        end
      end
      S_DONE: begin
        busywait = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      f3_q            <= '0;
      off_q           <= '0;
      wdata_q         <= '0;
      readdata_q      <= '0;
      err_q           <= 1'b0;
      mem_read_q      <= '0;
      mem_write_q     <= '0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      tmo_q           <= '0;
    end else begin
      state_q         <= state_d;
      f3_q            <= f3_d;
      off_q           <= off_d;
      wdata_q         <= wdata_d;
      readdata_q      <= readdata_d;
      err_q           <= err_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      tmo_q           <= tmo_d;
    end
  end

  assign readdata      = readdata_q;
  assign access_err    = err_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// tb_dmem_access_ctrl: directed scoreboard bench for dmem_access_ctrl against a behavioural word memory.
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  read;
  logic [2:0]  write;
  logic [31:0] address, writedata, readdata;
  logic        busywait, access_err;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_busywait;

  logic [31:0] mem [0:15];
  logic        mem_init;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    logic        mrd;
    logic [31:0] maddr;
    logic        mwr;
    logic [31:0] wword;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  dmem_access_ctrl #(.ADDR_WIDTH(32), .BUSY_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait), .access_err(access_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  assign mem_readdata = mem[mem_address[5:2]];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899AABB;
    end else if (mem_write == 3'b110 && !mem_busywait) begin
      mem[mem_address[5:2]] <= mem_writedata;
    end
  end

  task automatic check(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s %s: observed %h, expected %h", tag, what, obs, exp);
    end
  endtask

  task automatic expect_acc(input string tag, input logic [31:0] rdata, input logic err,
                            input int stalls, input logic mrd, input logic [31:0] maddr,
                            input logic mwr, input logic [31:0] wword);
    exp_t e;
    e.tag = tag; e.rdata = rdata; e.err = err; e.stalls = stalls;
    e.mrd = mrd; e.maddr = maddr; e.mwr = mwr; e.wword = wword;
    sb.push_back(e);
  endtask

  // Drives one request, holds it until busywait drops, then scores the DONE cycle.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int bw);
    exp_t        e;
    int          stalls = 0;
    int          edges = 0;
    logic        done = 1'b0;
    logic        saw_rd = 1'b0;
    logic        saw_wr = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_word = '0;
    @(negedge clock);
    read = rd; write = wr; address = addr; writedata = wd; mem_busywait = (bw > 0);
    while (!done && stalls < 40) begin
      #1;
      if (mem_read == 4'b1010) begin saw_rd = 1'b1; rd_addr = mem_address; end
      if (mem_write == 3'b110) begin saw_wr = 1'b1; wr_word = mem_writedata; end
      if (!busywait) done = 1'b1;
      else begin
        stalls++;
        @(negedge clock);
        edges++;
        mem_busywait = (edges <= bw);
      end
    end
    e = sb.pop_front();
    check(e.tag, "completed", {31'd0, done}, 32'd1);
    check(e.tag, "stall cycles", 32'(stalls), 32'(e.stalls));
    check(e.tag, "access_err", {31'd0, access_err}, {31'd0, e.err});
    check(e.tag, "readdata", readdata, e.rdata);
    check(e.tag, "mem_read issued", {31'd0, saw_rd}, {31'd0, e.mrd});
    if (e.mrd) check(e.tag, "mem_address", rd_addr, e.maddr);
    check(e.tag, "mem_write issued", {31'd0, saw_wr}, {31'd0, e.mwr});
    if (e.mwr) check(e.tag, "mem_writedata", wr_word, e.wword);
    @(negedge clock);
    read = 4'b0; write = 3'b0; mem_busywait = 1'b0;
  endtask

  initial begin
    reset = 1'b1; read = 4'b0; write = 3'b0; address = '0; writedata = '0;
    mem_busywait = 1'b0; mem_init = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    mem_init = 1'b0;
    check("reset", "readdata", readdata, 32'h0);
    check("reset", "access_err", {31'd0, access_err}, 32'h0);
    check("reset", "mem_read", {28'd0, mem_read}, 32'h0);
    check("reset", "mem_write", {29'd0, mem_write}, 32'h0);
    check("reset", "mem_address", mem_address, 32'h0);
    check("reset", "mem_writedata", mem_writedata, 32'h0);
    check("reset", "busywait", {31'd0, busywait}, 32'h0);
    reset = 1'b0;

    expect_acc("LB@3", 32'hFFFFFF88, 1'b0, 2, 1'b1, 32'h0, 1'b0, 32'h0);
    access(4'b1000, 3'b000, 32'h3, 32'h0, 0);
    expect_acc("LBU@3", 32'h00000088, 1'b0, 2, 1'b1, 32'h0, 1'b0, 32'h0);
    access(4'b1100, 3'b000, 32'h3, 32'h0, 0);
    expect_acc("SW@4", 32'h00000088, 1'b0, 2, 1'b0, 32'h0, 1'b1, 32'h11223344);
    access(4'b0000, 3'b110, 32'h4, 32'h11223344, 0);
    check("SW@4", "memory word", mem[1], 32'h11223344);
    expect_acc("LH@6", 32'h00001122, 1'b0, 2, 1'b1, 32'h4, 1'b0, 32'h0);
    access(4'b1001, 3'b000, 32'h6, 32'h0, 0);
    expect_acc("LHU@4", 32'h00003344, 1'b0, 2, 1'b1, 32'h4, 1'b0, 32'h0);
    access(4'b1101, 3'b000, 32'h4, 32'h0, 0);
    expect_acc("SB@5", 32'h00003344, 1'b0, 3, 1'b1, 32'h4, 1'b1, 32'h1122EE44);
    access(4'b0000, 3'b100, 32'h5, 32'hFFFFFFEE, 0);
    check("SB@5", "memory word", mem[1], 32'h1122EE44);
    expect_acc("LB@5", 32'hFFFFFFEE, 1'b0, 2, 1'b1, 32'h4, 1'b0, 32'h0);
    access(4'b1000, 3'b000, 32'h5, 32'h0, 0);
    expect_acc("SH@2", 32'hFFFFFFEE, 1'b0, 3, 1'b1, 32'h0, 1'b1, 32'h8001AABB);
    access(4'b0000, 3'b101, 32'h2, 32'h12348001, 0);
    expect_acc("LH@2", 32'hFFFF8001, 1'b0, 2, 1'b1, 32'h0, 1'b0, 32'h0);
    access(4'b1001, 3'b000, 32'h2, 32'h0, 0);

    expect_acc("LW@2 misaligned", 32'hFFFF8001, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    access(4'b1010, 3'b000, 32'h2, 32'h0, 0);
    expect_acc("LD funct3 011", 32'hFFFF8001, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    access(4'b1011, 3'b000, 32'h0, 32'h0, 0);
    expect_acc("ST size 11", 32'hFFFF8001, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    access(4'b0000, 3'b111, 32'h0, 32'h0, 0);
    expect_acc("SH@1 misaligned", 32'hFFFF8001, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    access(4'b0000, 3'b101, 32'h1, 32'h0, 0);
    check("SH@1 misaligned", "memory word", mem[0], 32'h8001AABB);

    // Load and store requested together
    @(negedge clock);
    read = 4'b1010; write = 3'b110; address = 32'h4; writedata = 32'hDEADBEEF;
    @(posedge clock); #1;
    check("LD+ST", "access_err", {31'd0, access_err}, 32'h1);
    check("LD+ST", "mem_read", {28'd0, mem_read}, 32'h0);
    check("LD+ST", "mem_write", {29'd0, mem_write}, 32'h0);
    @(negedge clock);
    read = 4'b0; write = 3'b0;
    @(posedge clock); #1;
    check("LD+ST", "access_err after DONE", {31'd0, access_err}, 32'h0);
    check("LD+ST", "memory word", mem[1], 32'h1122EE44);

    expect_acc("LW@0", 32'h8001AABB, 1'b0, 2, 1'b1, 32'h0, 1'b0, 32'h0);
    access(4'b1010, 3'b000, 32'h0, 32'h0, 0);
    expect_acc("LW@4 timeout", 32'h8001AABB, 1'b1, 5, 1'b1, 32'h4, 1'b0, 32'h0);
    access(4'b1010, 3'b000, 32'h4, 32'h0, 1000);
    expect_acc("SW@8 2 waits", 32'h8001AABB, 1'b0, 4, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
    access(4'b0000, 3'b110, 32'h8, 32'hCAFEF00D, 2);
    check("SW@8 2 waits", "memory word", mem[2], 32'hCAFEF00D);
    expect_acc("LW@8", 32'hCAFEF00D, 1'b0, 2, 1'b1, 32'h8, 1'b0, 32'h0);
    access(4'b1010, 3'b000, 32'h8, 32'h0, 0);

    // Reset while the RMW write phase is stalled by memory
    @(negedge clock);
    write = 3'b100; address = 32'h4; writedata = 32'h00000055; mem_busywait = 1'b0;
    @(negedge clock);
    @(negedge clock);
    mem_busywait = 1'b1;
    #1;
    check("RMW reset", "mem_write before", {29'd0, mem_write}, 32'h6);
    check("RMW reset", "merged word", mem_writedata, 32'h1122EE55);
    reset = 1'b1;
    #1;
    check("RMW reset", "mem_write", {29'd0, mem_write}, 32'h0);
    check("RMW reset", "mem_read", {28'd0, mem_read}, 32'h0);
    check("RMW reset", "mem_writedata", mem_writedata, 32'h0);
    check("RMW reset", "readdata", readdata, 32'h0);
    write = 3'b0;
    @(negedge clock);
    reset = 1'b0; mem_busywait = 1'b0;
    check("RMW reset", "memory word", mem[1], 32'h1122EE44);

    expect_acc("LW@4 after reset", 32'h1122EE44, 1'b0, 2, 1'b1, 32'h4, 1'b0, 32'h0);
    access(4'b1010, 3'b000, 32'h4, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
